disp_io_bridge: RTL and testbench

DISP_IO_BRIDGE -- requirements
Module: disp_io_bridge

---
 rtl/disp_io_bridge.sv | 183 ++++++++++++++++++
 tb/tb_disp_io_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_io_bridge.sv
// disp_io_bridge: CPU-mapped bridge to a 7-segment display driver.
//
// Registers (byte addresses):
//   BASE_ADDR     VALUE  32-bit value shown on the display (byte-enable writes)
//   BASE_ADDR+4   CTRL   bit0 DEC (rw), bit1 BUSY (ro), bit2 OVF (ro)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   io_we         CPU store strobe
//   io_addr       CPU byte address
//   io_be         byte enables for VALUE writes
//   io_wdata      CPU store data
//   io_rdata      combinational readback
//   disp_data     eight hex nibbles to the display driver (nibble 0 rightmost)
//   disp_data_en  one-cycle load strobe to the display driver
//
// Build option: define DISP_BCD_DEC_EN to include decimal mode (shift-add-3
// binary-to-BCD conversion, BUSY and OVF). Without it every refresh is hex.
//
// FSM (decimal build only):
//   state | meaning
//   IDLE  | no conversion running (a pending start may be flagged in start_q)
//   CONV  | one VALUE bit shifted into the BCD accumulator per cycle, MSB first
//   DONE  | result and strobe presented on disp_data / disp_data_en

module disp_io_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_be,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [31:0] disp_data,
  output logic        disp_data_en
);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;

  logic [31:0] value_q, value_d;
  logic [31:0] disp_q;
  logic        en_q;
  logic        hit_val, hit_ctl, wr_acc;
  logic        dec_w, busy_w, ovf_w;

  assign hit_val = io_we && (io_addr == BASE_ADDR);
  assign hit_ctl = io_we && (io_addr == CTRL_ADDR);
  assign wr_acc  = hit_val || hit_ctl;

  always_comb begin
    value_d = value_q;
    if (hit_val) begin
      for (int i = 0; i < 4; i++) begin
        if (io_be[i]) value_d[8*i +: 8] = io_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    io_rdata = 32'd0;
    if (io_addr == BASE_ADDR)      io_rdata = value_q;
    else if (io_addr == CTRL_ADDR) io_rdata = {29'd0, ovf_w, busy_w, dec_w};
  end

  assign disp_data    = disp_q;
  assign disp_data_en = en_q;

`ifdef DISP_BCD_DEC_EN

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q;
  logic        dec_q, dec_d;
  logic        ovf_q;
  logic        start_q;
  logic [4:0]  cnt_q;
  logic [31:0] shreg_q;
  logic [39:0] bcd_q, bcd_nxt;

  // Add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [39:0] bcd_step(input logic [39:0] acc, input logic b);
    logic [39:0] adj;
    adj = acc;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return (adj << 1) | {39'd0, b};
  endfunction

  assign dec_d   = hit_ctl ? io_wdata[0] : dec_q;
  assign bcd_nxt = bcd_step(bcd_q, shreg_q[31]);

  assign dec_w  = dec_q;
  assign ovf_w  = ovf_q;
  // The start_q cycle counts as busy so BUSY covers write+1 through DONE.
  assign busy_w = start_q || (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 32'd0;
      dec_q   <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= 32'd0;
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      cnt_q   <= 5'd0;
      shreg_q <= 32'd0;
      bcd_q   <= 40'd0;
    end else begin
      value_q <= value_d;
      dec_q   <= dec_d;
      en_q    <= 1'b0;
      if (wr_acc) begin
        // Any accepted write aborts a running conversion and restarts refresh.
        state_q <= ST_IDLE;
        if (!dec_d) begin
          disp_q  <= value_d;
          en_q    <= 1'b1;
          ovf_q   <= 1'b0;
          start_q <= 1'b0;
        end else begin
          start_q <= 1'b1;
        end
      end else if (start_q) begin
        start_q <= 1'b0;
        state_q <= ST_CONV;
        shreg_q <= value_q;
        bcd_q   <= 40'd0;
        cnt_q   <= 5'd31;
      end else begin
        case (state_q)
          ST_CONV: begin
            bcd_q   <= bcd_nxt;
            shreg_q <= {shreg_q[30:0], 1'b0};
            if (cnt_q == 5'd0) begin
              // Last bit: load the result now so the strobe lands in DONE.
              state_q <= ST_DONE;
              en_q    <= 1'b1;
              if (value_q > 32'd99_999_999) begin
                disp_q <= 32'h9999_9999;
                ovf_q  <= 1'b1;
              end else begin
                disp_q <= bcd_nxt[31:0];
                ovf_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`else

  assign dec_w  = 1'b0;
  assign busy_w = 1'b0;
  assign ovf_w  = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 32'd0;
      disp_q  <= 32'd0;
      en_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      en_q    <= wr_acc;
      if (wr_acc) disp_q <= value_d;
    end
  end

`endif

endmodule

// File: tb/tb_disp_io_bridge.sv
module tb_disp_io_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam logic [31:0] CTRL = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_we;
  logic [31:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [31:0] disp_data;
  logic        disp_data_en;

  disp_io_bridge #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .disp_data(disp_data),
    .disp_data_en(disp_data_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic        rst_last = 1'b0;
  logic [31:0] prev_disp = 32'd0;

  // Bench-side reference state
  logic [31:0] val_m = 32'd0;
  logic        dec_m = 1'b0;
  logic        ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r, t;
    r = 32'd0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_last <= rst_n;
  end

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (disp_data_en === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", disp_data, 32'hxxxx_xxxx);
      end else begin
        e = sbq.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.c));
        chk("disp_data", disp_data, e.d);
      end
    end else if (rst_last === 1'b1 && disp_data !== prev_disp) begin
      chk("disp_hold", disp_data, prev_disp);
    end
    prev_disp = disp_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    io_we = 1'b1; io_addr = a; io_be = be; io_wdata = d;
    if (a == BASE || a == CTRL) begin
      if (a == BASE) begin
        for (int i = 0; i < 4; i++) if (be[i]) val_m[8*i +: 8] = d[8*i +: 8];
      end
`ifdef DISP_BCD_DEC_EN
      if (a == CTRL) dec_m = d[0];
`endif
      // Pending (not yet due) conversion strobes are aborted by this write.
      while (sbq.size() > 0 && sbq[$].c > cyc) void'(sbq.pop_back());
      if (dec_m) begin
        ovf_m = (val_m > 32'd99_999_999);
        e.d = ovf_m ? 32'h9999_9999 : to_bcd(val_m);
        e.c = cyc + 34;
      end else begin
        ovf_m = 1'b0;
        e.d = val_m;
        e.c = cyc + 1;
      end
      sbq.push_back(e);
    end
    tick(1);
    io_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    io_addr = a;
    #1;
    chk(tag, io_rdata, e);
  endtask

  function automatic logic [31:0] ctrl_m();
    return {29'd0, ovf_m, 1'b0, dec_m};
  endfunction

  initial begin
    rst_n = 1'b0; io_we = 1'b0; io_addr = 32'd0; io_be = 4'd0; io_wdata = 32'd0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    rd("rst_value", BASE, 32'd0);
    rd("rst_ctrl", CTRL, 32'd0);
    chk("rst_disp", disp_data, 32'd0);
    chk("rst_en", {31'd0, disp_data_en}, 32'd0);

    // Hex refresh, full word
    wr(BASE, 4'hF, 32'h1234_ABCD);
    tick(3);
    rd("value_full", BASE, 32'h1234_ABCD);

    // Byte-enable merge
    wr(BASE, 4'hF, 32'hFFFF_FFFF);
    tick(2);
    wr(BASE, 4'b0010, 32'h0000_5500);
    tick(2);
    rd("value_merge", BASE, 32'hFFFF_55FF);
    chk("disp_merge", disp_data, 32'hFFFF_55FF);

    // be=0 still refreshes; unmapped address ignored and reads 0
    wr(BASE, 4'h0, 32'hDEAD_BEEF);
    tick(2);
    wr(BASE + 32'd8, 4'hF, 32'hDEAD_BEEF);
    tick(2);
    rd("unmapped_rd", BASE + 32'd8, 32'd0);
    rd("value_be0", BASE, 32'hFFFF_55FF);

    // Enter decimal mode (current value overflows)
    wr(CTRL, 4'hF, 32'hFFFF_FFFF);
    tick(40);
    rd("ctrl_dec_ovf", CTRL, ctrl_m());

    // Decimal conversion with BUSY window
    wr(BASE, 4'hF, 32'd12345678);
    io_addr = CTRL;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      chk("busy", {31'd0, io_rdata[1]}, {31'd0, (dec_m && k <= 34)});
    end
    tick(2);
    rd("ctrl_ovf0", CTRL, ctrl_m());

    // Overflow, then back to hex
    wr(BASE, 4'hF, 32'd100_000_000);
    tick(40);
    rd("ctrl_ovf1", CTRL, ctrl_m());
    wr(CTRL, 4'hF, 32'd0);
    tick(3);
    rd("ctrl_hex", CTRL, 32'd0);
    chk("disp_hex", disp_data, 32'h05F5_E100);

    // Abort: second write ten cycles after the first
    wr(CTRL, 4'hF, 32'd1);
    tick(40);
    wr(BASE, 4'hF, 32'd999);
    tick(9);
    wr(BASE, 4'hF, 32'd42);
    tick(40);
    chk("disp_after_abort", disp_data, dec_m ? 32'h0000_0042 : 32'd42);

    // Reset at cycle 20 of a conversion
    wr(BASE, 4'hF, 32'd87654321);
    tick(19);
    rst_n = 1'b0;
    while (sbq.size() > 0 && sbq[$].c > cyc) void'(sbq.pop_back());
    val_m = 32'd0; dec_m = 1'b0; ovf_m = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_disp", disp_data, 32'd0);
    chk("post_rst_en", {31'd0, disp_data_en}, 32'd0);
    rd("post_rst_ctrl", CTRL, 32'd0);
    rd("post_rst_value", BASE, 32'd0);
    tick(40);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
